rom_fetch_unit: RTL and testbench

- Initiator side of the program-ROM read interface for the 8051 core: drives the 16-bit byte address into the program ROM and captures the returned byte.
- The program ROM is a synchronous read: it samples the address on a clock edge and presents the byte after that edge.
- Buffers fetched opcode/operand bytes in a small prefetch FIFO and hands them to the instruction decoder over a valid/ready handshake.
- Handles jumps/branches by redirecting the fetch PC and flushing stale bytes.

---
 rtl/rom_fetch_unit.sv | 106 ++++++++++
 tb/tb_rom_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
// Program-ROM fetch front end: issues byte addresses, buffers returned bytes.
// Optional stall statistics counter enabled by defining FETCH_STATS_EN.
module rom_fetch_unit #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    input  logic        jump,
    input  logic [15:0] jump_addr,
    output logic [7:0]  byte_out,
    output logic [15:0] byte_pc,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [15:0] stall_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [15:0]   fetch_pc;
    logic [15:0]   rd_pc;
    logic          rd_pend;
    logic [7:0]    mem_byte [FIFO_DEPTH];
    logic [15:0]   mem_pc   [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW+1:0] credit;
    logic          issue;
    logic          push;
    logic          pop;

    // Credits already committed: buffered bytes plus the read in flight.
    assign credit     = {1'b0, count} + {{(AW + 1){1'b0}}, rd_pend};
    assign issue      = credit < (AW + 2)'(FIFO_DEPTH);
    assign push       = rd_pend;
    assign byte_valid = (count != '0);
    assign pop        = byte_valid & byte_ready;

    assign rom_addr = fetch_pc;
    assign byte_out = byte_valid ? mem_byte[rd_ptr] : 8'h00;
    assign byte_pc  = byte_valid ? mem_pc[rd_ptr]   : 16'h0000;

    // Fetch PC, in-flight read tracking and FIFO occupancy; jump flushes all.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rd_pend  <= 1'b0;
            rd_pc    <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (jump) begin
            fetch_pc <= jump_addr;
            rd_pend  <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            rd_pend <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 16'h0001;
                rd_pc    <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: capture the returned byte with the address it came from.
    always_ff @(posedge clock) begin
        if (!reset && !jump && push) begin
            mem_byte[wr_ptr] <= rom_data;
            mem_pc[wr_ptr]   <= rd_pc;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] stall_q;

    // Count cycles the decoder wanted a byte and none was ready; saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else if (byte_ready && !byte_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'h0001;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit with a synchronous-read ROM model.
// ROM contents are ROM[i] = i[7:0].
module tb_rom_fetch_unit;

`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        jump;
    logic [15:0] jump_addr;
    logic [7:0]  byte_out;
    logic [15:0] byte_pc;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] stall_count;

    int vectors = 0;
    int errors  = 0;

    rom_fetch_unit #(
        .FIFO_DEPTH (4),
        .RESET_PC   (16'h0000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .byte_out    (byte_out),
        .byte_pc     (byte_pc),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read program ROM.
    always @(posedge clock) rom_data <= rom_addr[7:0];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] want);
        vectors++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] st(input int n);
        return STATS ? 16'(n) : 16'h0000;
    endfunction

    logic [15:0] wrap_pc [4];
    logic [7:0]  wrap_by [4];

    initial begin
        wrap_pc[0] = 16'hFFFE; wrap_by[0] = 8'hFE;
        wrap_pc[1] = 16'hFFFF; wrap_by[1] = 8'hFF;
        wrap_pc[2] = 16'h0000; wrap_by[2] = 8'h00;
        wrap_pc[3] = 16'h0001; wrap_by[3] = 8'h01;

        reset      = 1'b1;
        jump       = 1'b0;
        jump_addr  = 16'h0000;
        byte_ready = 1'b1;
        tick();
        tick();
        chk("rst_addr",  rom_addr,    16'h0000);
        chk("rst_valid", byte_valid,  16'h0);
        chk("rst_out",   byte_out,    16'h00);
        chk("rst_pc",    byte_pc,     16'h0000);
        chk("rst_stall", stall_count, 16'h0000);

        // Stream from reset with decoder always ready.
        reset = 1'b0;
        tick();
        chk("a1_valid", byte_valid, 16'h0);
        chk("a1_addr",  rom_addr,   16'h0001);
        tick();
        chk("a2_valid", byte_valid,  16'h1);
        chk("a2_out",   byte_out,    16'h00);
        chk("a2_pc",    byte_pc,     16'h0000);
        chk("a2_stall", stall_count, st(2));
        for (int k = 3; k <= 7; k++) begin
            tick();
            chk("a_valid", byte_valid, 16'h1);
            chk("a_out",   byte_out,   16'(k - 2));
            chk("a_pc",    byte_pc,    16'(k - 2));
        end
        chk("a_stall", stall_count, st(2));

        // Backpressure: FIFO fills to 4, issue stops at address 4.
        reset      = 1'b1;
        byte_ready = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("bp_addr",  rom_addr,    16'h0004);
        chk("bp_valid", byte_valid,  16'h1);
        chk("bp_out",   byte_out,    16'h00);
        chk("bp_stall", stall_count, st(0));
        byte_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("bp_rel_out", byte_out, 16'(k));
            chk("bp_rel_pc",  byte_pc,  16'(k));
        end

        // Jump with 3 buffered bytes and a read in flight.
        reset      = 1'b1;
        byte_ready = 1'b0;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("jpre_addr", rom_addr, 16'h0004);
        chk("jpre_out",  byte_out, 16'h00);
        jump       = 1'b1;
        jump_addr  = 16'h0100;
        byte_ready = 1'b1;
        tick();
        jump = 1'b0;
        chk("j0_valid", byte_valid, 16'h0);
        chk("j0_addr",  rom_addr,   16'h0100);
        tick();
        chk("j1_valid", byte_valid, 16'h0);
        chk("j1_addr",  rom_addr,   16'h0101);
        tick();
        chk("j2_valid", byte_valid,  16'h1);
        chk("j2_pc",    byte_pc,     16'h0100);
        chk("j2_out",   byte_out,    16'h00);
        chk("j2_stall", stall_count, st(2));
        tick();
        chk("j3_pc",  byte_pc,  16'h0101);
        chk("j3_out", byte_out, 16'h01);

        // Back-to-back jumps, last one to FFFE, then wrap through 0000.
        jump      = 1'b1;
        jump_addr = 16'h2000;
        tick();
        jump_addr = 16'hFFFE;
        tick();
        jump = 1'b0;
        chk("k1_valid", byte_valid, 16'h0);
        chk("k1_addr",  rom_addr,   16'hFFFE);
        tick();
        chk("k2_valid", byte_valid, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_valid", byte_valid, 16'h1);
            chk("wrap_pc",    byte_pc,    wrap_pc[i]);
            chk("wrap_out",   byte_out,   16'(wrap_by[i]));
        end
        chk("wrap_stall", stall_count, st(5));

        // Fill the FIFO, then reset mid-stream.
        byte_ready = 1'b0;
        repeat (6) tick();
        chk("full_pc",   byte_pc,  16'h0001);
        chk("full_addr", rom_addr, 16'h0005);
        reset      = 1'b1;
        byte_ready = 1'b1;
        tick();
        chk("r0_valid", byte_valid,  16'h0);
        chk("r0_addr",  rom_addr,    16'h0000);
        chk("r0_out",   byte_out,    16'h00);
        chk("r0_stall", stall_count, 16'h0000);
        reset = 1'b0;
        tick();
        chk("r1_valid", byte_valid, 16'h0);
        tick();
        chk("r2_valid", byte_valid,  16'h1);
        chk("r2_out",   byte_out,    16'h00);
        chk("r2_pc",    byte_pc,     16'h0000);
        chk("r2_stall", stall_count, st(2));
        tick();
        chk("r3_out", byte_out, 16'h01);
        chk("r3_pc",  byte_pc,  16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
